// File: rtl/countdown_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package countdown_pkg;

    localparam int unsigned DefaultWidth = 4;

    typedef enum logic [0:0] {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with valid/ready load, count enable, optional auto-reload,
// synchronous abort and a registered single-cycle terminal-count pulse.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
);

    localparam logic [WIDTH-1:0] CountOne = WIDTH'(1);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] reload_q;
    logic             tc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            tc_q <= 1'b0;
            if (abort) begin
                // Abort wins over a same-edge load or terminal edge.
                state_q <= IDLE;
                count_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (load_valid && load_ready) begin
                            count_q  <= load_value;
                            reload_q <= load_value;
                            if (load_value != '0) begin
                                state_q <= RUN;
                            end else begin
                                tc_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (en) begin
                            // Terminal edge is at 1, so RUN never decrements through 0.
                            if (count_q == CountOne) begin
                                tc_q <= 1'b1;
                                if (auto_reload) begin
                                    count_q <= reload_q;
                                end else begin
                                    count_q <= '0;
                                    state_q <= IDLE;
                                end
                            end else begin
                                count_q <= count_q - CountOne;
                            end
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        count_q <= '0;
                    end
                endcase
            end
        end
    end

    assign count      = count_q;
    assign tc         = tc_q;
    assign busy       = (state_q == RUN);
    assign load_ready = (state_q == IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: expected cycle results are queued as stimulus is
// driven and popped after each clock edge.
module tb_countdown_timer;

    typedef struct packed {
        logic [3:0] cnt;
        logic       tc;
        logic       busy;
        logic       ready;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] load_value = '0;
    logic       en = 1'b0;
    logic       auto_reload = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] count;
    logic       busy;
    logic       tc;

    int   n_run = 0;
    int   n_fail = 0;
    obs_t exp_q[$];
    obs_t got;
    obs_t want;

    countdown_timer #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .en         (en),
        .auto_reload(auto_reload),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(int c, bit t, bit b, bit r);
        obs_t o;
        o.cnt   = 4'(c);
        o.tc    = t;
        o.busy  = b;
        o.ready = r;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.cnt   = count;
        o.tc    = tc;
        o.busy  = busy;
        o.ready = load_ready;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("cnt=%0d tc=%b busy=%b rdy=%b", o.cnt, o.tc, o.busy, o.ready);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        exp_q.push_back(mk(0, 0, 0, 1));
        got = sample(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_held: got %s want %s", fmt(got), fmt(want));
        end
        reset_n = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 0, 1));
        got = sample(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_release: got %s want %s", fmt(got), fmt(want));
        end
        tick();
    endtask

    task automatic test_oneshot();
        load_valid = 1'b1; load_value = 4'd5; en = 1'b1; auto_reload = 1'b0;
        for (int k = 0; k <= 6; k++) begin
            if (k == 6) exp_q.push_back(mk(0, 0, 0, 1));
            else        exp_q.push_back(mk(5 - k, k == 5, k < 5, k == 5));
            tick();
            load_valid = 1'b0;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL oneshot[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_periodic();
        int pulses = 0;
        load_valid = 1'b1; load_value = 4'd3; en = 1'b1; auto_reload = 1'b1;
        for (int j = 0; j <= 12; j++) begin
            exp_q.push_back(mk(3 - (j % 3), (j > 0) && (j % 3 == 0), 1, 0));
            tick();
            load_valid = 1'b0;
            if (tc) pulses++;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL periodic[%0d]: got %s want %s", j, fmt(got), fmt(want));
            end
        end
        n_run++;
        if (pulses !== 4) begin
            n_fail++;
            $display("FAIL periodic_pulses: got %0d want 4", pulses);
        end
        abort = 1'b1;
        exp_q.push_back(mk(0, 0, 0, 1));
        tick();
        abort = 1'b0; auto_reload = 1'b0;
        got = sample(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL periodic_abort: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_enable_pause();
        int   cnts[8] = '{4, 3, 2, 2, 2, 1, 0, 0};
        logic ens[8]  = '{1, 1, 1, 0, 0, 1, 1, 1};
        load_valid = 1'b1; load_value = 4'd4; auto_reload = 1'b0;
        for (int k = 0; k < 8; k++) begin
            en = ens[k];
            exp_q.push_back(mk(cnts[k], k == 6, k < 6, k >= 6));
            tick();
            load_valid = 1'b0;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL enable_pause[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        en = 1'b1;
    endtask

    task automatic test_zero_load();
        load_valid = 1'b1; load_value = 4'd0;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(mk(0, k == 0, 0, 1));
            tick();
            load_valid = 1'b0;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL zero_load[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_abort();
        // Load 4, then hold load_valid with 9 during RUN; abort lands on the terminal edge.
        int cnts[5] = '{4, 3, 2, 1, 0};
        load_valid = 1'b1; load_value = 4'd4; en = 1'b1; auto_reload = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) load_value = 4'd9;
            if (k == 4) abort = 1'b1;
            exp_q.push_back(mk(cnts[k], 0, k < 4, k == 4));
            tick();
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL abort_run[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        // Abort in IDLE blocks a simultaneous load handshake.
        load_value = 4'd5;
        exp_q.push_back(mk(0, 0, 0, 1));
        tick();
        abort = 1'b0; load_valid = 1'b0;
        got = sample(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL abort_idle_load: got %s want %s", fmt(got), fmt(want));
        end
        exp_q.push_back(mk(0, 0, 0, 1));
        tick();
        got = sample(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL abort_idle_after: got %s want %s", fmt(got), fmt(want));
        end
    endtask

    task automatic test_async_reset();
        load_valid = 1'b1; load_value = 4'd9; en = 1'b1; auto_reload = 1'b0;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(9 - k, 0, 1, 0));
            tick();
            load_valid = 1'b0;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL async_pre[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        #2;
        reset_n = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 1));
        #1;
        got = sample(); want = exp_q.pop_front(); n_run++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL async_reset_now: got %s want %s", fmt(got), fmt(want));
        end
        tick();
        reset_n = 1'b1;
        load_valid = 1'b1; load_value = 4'd2;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(mk(2 - k, k == 2, k < 2, k == 2));
            tick();
            load_valid = 1'b0;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL async_post[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
    endtask

    task automatic test_back_to_back();
        // One-shot of 1, reloaded in the tc cycle with 2.
        int   cnts[5] = '{1, 0, 2, 1, 0};
        logic lv[5]   = '{1, 0, 1, 0, 0};
        en = 1'b1; auto_reload = 1'b0;
        for (int k = 0; k < 5; k++) begin
            load_valid = lv[k];
            load_value = (k == 0) ? 4'd1 : 4'd2;
            exp_q.push_back(mk(cnts[k], (k == 1) || (k == 4), cnts[k] != 0, cnts[k] == 0));
            tick();
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        // Periodic reload of 1 gives tc on consecutive cycles.
        load_valid = 1'b1; load_value = 4'd1; auto_reload = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(1, k > 0, 1, 0));
            tick();
            load_valid = 1'b0;
            got = sample(); want = exp_q.pop_front(); n_run++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reload_one[%0d]: got %s want %s", k, fmt(got), fmt(want));
            end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; auto_reload = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_oneshot();
        test_periodic();
        test_enable_pause();
        test_zero_load();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
